// File: rtl/array_rw_sched.sv
// rtl/array_rw_sched.sv - shares one RW port of a masked-write SRAM between a write and a read requester.
// Read data goes into a credit-limited response FIFO. Define ARRAY_SCHED_INIT_EN to zero-fill the array after reset.
module array_rw_sched #(
  parameter int ADDR_W     = 9,
  parameter int LANE_W     = 10,
  parameter int LANES      = 8,
  parameter int RESP_DEPTH = 2,
  localparam int DATA_W    = LANES * LANE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES-1:0]  wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              arr_en,
  output logic              arr_wmode,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [LANES-1:0]  arr_wmask,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 2);

  logic              sweep;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef ARRAY_SCHED_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (&init_addr_q) state_d = ST_RUN;
    end
  end

  assign init_done  = (state_q == ST_RUN);
  // Gated by reset_n so the macro port stays idle while reset is held.
  assign sweep      = (state_q == ST_INIT) && reset_n;
  assign sweep_addr = init_addr_q;
`else
  logic run_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign init_done  = run_q;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
`endif

  logic              prio_wr_q;
  logic              rd_inflight_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  credits;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic              wr_elig, rd_elig, grant_wr, grant_rd;
  logic              push, pop, fifo_full;

  // Credits only use registered state, so resp_ready never reaches rd_ready combinationally.
  assign credits   = CNT_W'(rd_inflight_q) + count_q;
  assign wr_elig   = wr_valid && init_done;
  assign rd_elig   = rd_valid && init_done && (credits < CNT_W'(RESP_DEPTH));
  assign grant_wr  = wr_elig && (!rd_elig || prio_wr_q);
  assign grant_rd  = rd_elig && (!wr_elig || !prio_wr_q);
  assign wr_ready  = grant_wr;
  assign rd_ready  = grant_rd;

  assign push      = rd_inflight_q;
  assign pop       = resp_valid && resp_ready;
  assign fifo_full = (count_q == CNT_W'(RESP_DEPTH));
  assign resp_valid = (count_q != '0);
  assign resp_data  = fifo_mem[rptr_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_wr_q     <= 1'b1;
      rd_inflight_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      if (wr_elig && rd_elig) prio_wr_q <= !prio_wr_q;
      rd_inflight_q <= grant_rd;
      if (push) wptr_q <= (wptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset; the occupancy count defines what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr_q] <= arr_rdata;
  end

  always_comb begin
    arr_en    = 1'b0;
    arr_wmode = 1'b0;
    arr_addr  = '0;
    arr_wmask = '0;
    arr_wdata = '0;
    if (sweep) begin
      arr_en    = 1'b1;
      arr_wmode = 1'b1;
      arr_addr  = sweep_addr;
      arr_wmask = '1;
    end else if (grant_wr) begin
      arr_en    = 1'b1;
      arr_wmode = 1'b1;
      arr_addr  = wr_addr;
      arr_wmask = wr_mask;
      arr_wdata = wr_data;
    end else if (grant_rd) begin
      arr_en    = 1'b1;
      arr_addr  = rd_addr;
    end
  end

  resp_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && fifo_full && !pop));

endmodule

// File: doc/array_rw_sched.md
Name: array_rw_sched

Overview:
- Arbiter and sequencer for a single-port 512x80 masked-write SRAM macro (8 lanes x 10 bits, 1-cycle registered read).
- Shares the macro's single RW port between one write requester and one read requester, each with a valid/ready handshake.
- Buffers read data into a small response FIFO with valid/ready, so consumer backpressure never corrupts or loses read data.
- Optionally zero-initialises the array after reset.

Parameters:
- ADDR_W, 9: array address width (depth = 2^ADDR_W).
- LANE_W, 10: bits per write-mask lane.
- LANES, 8: number of mask lanes. Data width DATA_W = LANES*LANE_W = 80.
- RESP_DEPTH, 2: response FIFO depth and read credit limit. Must be at least 1.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_mask  in  LANES  per-lane write enable.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when rd_valid && rd_ready.
- rd_addr  in  ADDR_W  read address.
- resp_valid  out  1  response FIFO head valid.
- resp_ready  in  1  consumer pops the head.
- resp_data  out  DATA_W  response FIFO head data.
- init_done  out  1  block is ready for traffic.
- arr_en  out  1  macro port enable.
- arr_wmode  out  1  1 = write, 0 = read.
- arr_addr  out  ADDR_W  macro address.
- arr_wmask  out  LANES  macro lane mask.
- arr_wdata  out  DATA_W  macro write data.
- arr_rdata  in  DATA_W  macro read data, valid the cycle after a read is issued.

Behaviour:
- Reset values: wr_ready=0, rd_ready=0, resp_valid=0, init_done=0, arr_en=0. Response FIFO empty, credit count 0, priority pointer = write, read-in-flight flag 0.
- init_done rises on the first clock edge after reset release, or at the end of the init sweep when the optional feature is compiled in.
- Eligibility:
  - Write eligible: wr_valid && init_done.
  - Read eligible: rd_valid && init_done && credits < RESP_DEPTH.
  - credits = read-in-flight + FIFO occupancy.
- Grant, combinational, at most one per cycle:
  - Only one side eligible: that side is granted.
  - Both eligible: the side named by the priority pointer is granted, and the pointer flips to the other side.
  - Pointer is unchanged when there is no contention.
- wr_ready and rd_ready equal their grant signal and may depend combinationally on the other requester's valid.
- Granted write: arr_en=1, arr_wmode=1, and addr/mask/data are passed through in the same cycle. wr_mask=0 still consumes the slot; the array is unchanged.
- Granted read: arr_en=1, arr_wmode=0, arr_addr=rd_addr. Read-in-flight is set for the next cycle.
  - In that next cycle, arr_rdata is pushed into the FIFO.
  - resp_valid is asserted 2 cycles after the rd handshake.
- Not granted: arr_en=0. arr_addr, arr_wmask and arr_wdata are 0.
- Ordering:
  - Array operations execute strictly in grant order. A read granted after a write to the same address returns the new data.
  - Responses are returned in read-grant order.
- FIFO:
  - Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees a slot first).
  - The credit rule makes overflow impossible. A push when full is a design error and is asserted in simulation.
- Credits may reach RESP_DEPTH. rd_ready then stays low until a pop happens; the pop becomes visible the next cycle. No combinational path from resp_ready to rd_ready.
- Reset asserted mid-operation: the in-flight read and all FIFO contents are discarded, and all state returns to reset values immediately. Array contents are untouched.

Optional Feature:
- Macro: ARRAY_SCHED_INIT_EN.
- Defined:
  - After reset release, state INIT sweeps addresses 0 to 2^ADDR_W-1, one per cycle: arr_en=1, arr_wmode=1, arr_wmask all ones, arr_wdata=0.
  - wr_ready and rd_ready are held at 0 during INIT.
  - After the last address (512 cycles), state moves to RUN and init_done=1.
  - Reset during INIT restarts the sweep from address 0.
- Undefined: no INIT state; RUN is entered directly and init_done=1 one cycle after reset release.

Test Plan:
- Write addr 0x05, mask 0xFF, data 0x123456789ABCDEF01234. Then read 0x05 with resp_ready=1 -> resp_valid 2 cycles after the rd handshake, resp_data = written value.
- Write addr 0x10 with all lanes = 0x3FF, mask 0xFF. Then write data 0, mask 0x01. Then read 0x10 -> lane 0 = 0, lanes 1-7 = 0x3FF.
- rd_valid and wr_valid held high for 8 cycles with resp_ready=1 -> grants alternate W,R,W,R,... starting with write, and the FIFO never exceeds RESP_DEPTH.
- resp_ready=0 with 4 reads offered -> exactly 2 reads accepted, then rd_ready=0 while writes still proceed. Raise resp_ready -> responses drain in order and reads resume.
- With ARRAY_SCHED_INIT_EN: release reset -> 512 zero writes, init_done at cycle 512. A read of 0x1FF then returns 0.
- Assert reset_n=0 one cycle after a read grant -> resp_valid=0 and no response appears after reset release.
